// File: rtl/tone_gen.sv
// Programmable square-wave tone generator on the 8-bit I/O bus.
// Half-period divider, timed bursts in TICK_CYCLES units, busy/done status.
module tone_gen #(
   parameter int DIV_W       = 16,
   parameter int TICK_CYCLES = 1000,
   parameter int DUR_W       = 8
) (
   input  logic       clk_in,
   input  logic       rst_n,
   input  logic       CS_N,
   input  logic       IOW_N,
   input  logic [1:0] addr,
   input  logic [7:0] din,
   output logic       tone_out,
   output logic       busy,
   output logic       done
);

   localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

   typedef enum logic {IDLE, RUN} state_t;

   typedef struct packed {
      logic       stb;
      logic [1:0] addr;
      logic [7:0] data;
   } wr_req_t;

   state_t            state;
   logic              wr_act, wr_act_d;
   wr_req_t           req;
   logic [DIV_W-1:0]  div_reg, div_cnt;
   logic [DUR_W-1:0]  dur_reg, dur_cnt;
   logic [TICK_W-1:0] tick_cnt;
   logic              mode;
   logic              ctrl_wr, tick_wrap;

   // One commit per strobe assertion: only the first cycle of a held strobe counts.
   always_comb begin
      wr_act    = ~CS_N & ~IOW_N;
      req.stb   = wr_act & ~wr_act_d;
      req.addr  = addr;
      req.data  = din;
      ctrl_wr   = req.stb && (req.addr == 2'd3);
      tick_wrap = (tick_cnt == TICK_LAST);
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         wr_act_d <= 1'b0;
         div_reg  <= '0;
         dur_reg  <= '0;
         div_cnt  <= '0;
         dur_cnt  <= '0;
         tick_cnt <= '0;
         mode     <= 1'b0;
         tone_out <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         wr_act_d <= wr_act;
         done     <= 1'b0;

         if (req.stb) begin
            unique case (req.addr)
               2'd0: div_reg[7:0]       <= req.data;
               2'd1: div_reg[DIV_W-1:8] <= req.data[DIV_W-9:0];
               2'd2: dur_reg            <= req.data[DUR_W-1:0];
               2'd3: mode               <= req.data[1];
            endcase
         end

         // A ctrl write overrides whatever the running burst would do this edge.
         if (ctrl_wr) begin
            tone_out <= 1'b0;
            if (req.data[0]) begin
               div_cnt  <= '0;
               tick_cnt <= '0;
               dur_cnt  <= dur_reg;
               if (req.data[1] && (dur_reg == '0)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  state <= RUN;
                  busy  <= 1'b1;
               end
            end else begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         end else if (state == RUN) begin
            if (div_cnt == div_reg) begin
               div_cnt  <= '0;
               tone_out <= ~tone_out;
            end else begin
               div_cnt <= div_cnt + 1'b1;
            end

            if (mode) begin
               tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;
               if (tick_wrap) begin
                  if (dur_cnt == DUR_W'(1)) begin
                     state    <= IDLE;
                     busy     <= 1'b0;
                     tone_out <= 1'b0;
                     done     <= 1'b1;
                  end else begin
                     dur_cnt <= dur_cnt - 1'b1;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_tone_gen.sv
// Self-checking bench for tone_gen: directed table, corner sequences, and
// randomized bus traffic against a cycle-time reference model.
module tb_tone_gen;

   localparam int TICK = 4;

   logic       clk_in = 1'b0;
   logic       rst_n  = 1'b0;
   logic       CS_N   = 1'b1;
   logic       IOW_N  = 1'b1;
   logic [1:0] addr   = 2'd0;
   logic [7:0] din    = 8'd0;
   logic       tone_out, busy, done;

   tone_gen #(.DIV_W(16), .TICK_CYCLES(TICK), .DUR_W(8)) dut (
      .clk_in(clk_in), .rst_n(rst_n), .CS_N(CS_N), .IOW_N(IOW_N),
      .addr(addr), .din(din), .tone_out(tone_out), .busy(busy), .done(done)
   );

   always #5 clk_in = ~clk_in;

   int n_chk = 0, n_fail = 0;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: time since start decides the waveform and burst end.
   bit          m_run, m_mode, m_done, m_wr_d, chk_en;
   int          m_t, m_durs;
   logic [15:0] m_div;
   logic [7:0]  m_dur;

   task automatic model_reset();
      m_run = 0; m_mode = 0; m_done = 0; m_wr_d = 0;
      m_t = 0; m_durs = 0; m_div = '0; m_dur = '0;
   endtask

   function automatic int m_tone();
      return m_run ? ((m_t / (int'(m_div) + 1)) % 2) : 0;
   endfunction

   task automatic model_edge();
      bit wr, stb;
      wr = !CS_N && !IOW_N;
      stb = wr && !m_wr_d;
      m_wr_d = wr;
      m_done = 0;
      if (m_run) begin
         m_t++;
         if (m_mode && m_t == m_durs * TICK) begin
            m_run = 0;
            m_done = 1;
         end
      end
      if (stb) begin
         case (addr)
            2'd0: m_div[7:0]  = din;
            2'd1: m_div[15:8] = din;
            2'd2: m_dur       = din;
            default: begin
               m_done = 0;
               if (din[0]) begin
                  m_t = 0; m_mode = din[1]; m_durs = m_dur;
                  if (din[1] && m_dur == 0) begin m_run = 0; m_done = 1; end
                  else m_run = 1;
               end else begin
                  m_run = 0;
               end
            end
         endcase
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      model_edge();
      #1;
      if (chk_en) begin
         check("tone", int'(tone_out), m_tone());
         check("busy", int'(busy), int'(m_run));
         check("done", int'(done), int'(m_done));
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      step();
      CS_N = 0; IOW_N = 0; addr = a; din = d;
      step();
      CS_N = 1; IOW_N = 1;
   endtask

   typedef struct {
      logic [15:0] div;
      logic [7:0]  dur;
      logic [7:0]  ctrl;
      int          busy_n;
      int          rise;
      int          done_n;
   } vec_t;

   vec_t tbl[5];

   initial begin
      int bc, dc, fr, t0, t1, t2, guard;
      logic prev;

      tbl[0] = '{div: 16'd0, dur: 8'd3, ctrl: 8'h03, busy_n: 12, rise: 1, done_n: 1};
      tbl[1] = '{div: 16'd2, dur: 8'd2, ctrl: 8'h03, busy_n: 8,  rise: 3, done_n: 1};
      tbl[2] = '{div: 16'd5, dur: 8'd0, ctrl: 8'h03, busy_n: 0,  rise: 0, done_n: 1};
      tbl[3] = '{div: 16'd1, dur: 8'd5, ctrl: 8'h03, busy_n: 20, rise: 2, done_n: 1};
      tbl[4] = '{div: 16'd3, dur: 8'd1, ctrl: 8'hF7, busy_n: 4,  rise: 0, done_n: 1};

      // Reset held with random bus traffic.
      chk_en = 0;
      model_reset();
      for (int i = 0; i < 10; i++) begin
         @(posedge clk_in); #1;
         CS_N = 1'($urandom); IOW_N = 1'($urandom);
         addr = 2'($urandom); din = 8'($urandom);
         check("rst_tone", int'(tone_out), 0);
         check("rst_busy", int'(busy), 0);
         check("rst_done", int'(done), 0);
      end
      CS_N = 1; IOW_N = 1;
      @(negedge clk_in) rst_n = 1;
      chk_en = 1;
      for (int i = 0; i < 4; i++) step();

      // Table of timed bursts.
      foreach (tbl[v]) begin
         wr(2'd0, tbl[v].div[7:0]);
         wr(2'd1, tbl[v].div[15:8]);
         wr(2'd2, tbl[v].dur);
         wr(2'd3, tbl[v].ctrl);
         bc = 0; dc = 0; fr = 0;
         for (int i = 0; i < 45; i++) begin
            if (i > 0) step();
            bc += int'(busy);
            dc += int'(done);
            if (tone_out && fr == 0) fr = i;
         end
         check($sformatf("tbl%0d_busy_len", v), bc, tbl[v].busy_n);
         check($sformatf("tbl%0d_first_rise", v), fr, tbl[v].rise);
         check($sformatf("tbl%0d_done_cnt", v), dc, tbl[v].done_n);
      end

      // Continuous, div=2: period 6.
      wr(2'd0, 8'd2); wr(2'd1, 8'd0); wr(2'd3, 8'h01);
      check("cont_busy", int'(busy), 1);
      dc = 0;
      for (int i = 1; i <= 100; i++) begin
         step();
         check("cont_wave", int'(tone_out), (i / 3) % 2);
         dc += int'(done);
      end
      wr(2'd3, 8'h00);
      check("cont_stop_tone", int'(tone_out), 0);
      check("cont_stop_busy", int'(busy), 0);
      check("cont_no_done", dc + int'(done), 0);

      // Long strobe: one start only.
      wr(2'd0, 8'd0); wr(2'd2, 8'd2);
      step();
      CS_N = 0; IOW_N = 0; addr = 2'd3; din = 8'h03;
      bc = 0; dc = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (i == 4) begin CS_N = 1; IOW_N = 1; end
         bc += int'(busy);
         dc += int'(done);
      end
      check("long_stb_busy", bc, 8);
      check("long_stb_done", dc, 1);

      // Live div_hi write in continuous run.
      wr(2'd0, 8'd1); wr(2'd1, 8'd0); wr(2'd3, 8'h01);
      for (int i = 0; i < 9; i++) step();
      chk_en = 0;
      wr(2'd1, 8'd1);
      t0 = -1; t1 = -1; t2 = -1; guard = 0;
      prev = tone_out;
      while (t2 < 0 && guard < 1200) begin
         step(); guard++;
         if (tone_out != prev) begin
            if (t0 < 0) t0 = guard; else if (t1 < 0) t1 = guard; else t2 = guard;
         end
         prev = tone_out;
      end
      check("live_div_toggles_seen", int'(t2 >= 0), 1);
      check("live_div_half1", t1 - t0, 258);
      check("live_div_half2", t2 - t1, 258);
      wr(2'd3, 8'h00);
      chk_en = 1;
      step();

      // Timed with dur=0.
      wr(2'd0, 8'd0); wr(2'd1, 8'd0); wr(2'd2, 8'd0); wr(2'd3, 8'h03);
      check("dur0_done", int'(done), 1);
      check("dur0_busy", int'(busy), 0);
      check("dur0_tone", int'(tone_out), 0);
      step();
      check("dur0_done_clr", int'(done), 0);

      // Async reset mid-burst, while tone is high.
      wr(2'd2, 8'd10); wr(2'd3, 8'h03);
      guard = 0;
      while (!tone_out && guard < 20) begin step(); guard++; end
      check("arst_pre_tone", int'(tone_out), 1);
      check("arst_pre_busy", int'(busy), 1);
      #2 rst_n = 0;
      #1;
      check("arst_tone", int'(tone_out), 0);
      check("arst_busy", int'(busy), 0);
      check("arst_done", int'(done), 0);
      model_reset();
      @(negedge clk_in) rst_n = 1;
      wr(2'd3, 8'h03);
      check("arst_dur_cleared", int'(done), 1);
      step();

      // Randomized traffic against the model.
      for (int n = 0; n < 300; n++) begin
         int op;
         op = int'($urandom_range(0, 5));
         if (op <= 1 && m_run) op = 2 + int'($urandom_range(0, 3));
         case (op)
            0: wr(2'd0, 8'($urandom_range(0, 6)));
            1: wr(2'd1, 8'd0);
            2: wr(2'd2, 8'($urandom_range(0, 6)));
            3: wr(2'd3, {6'($urandom), 2'($urandom)});
            default: repeat ($urandom_range(1, 30)) step();
         endcase
      end
      wr(2'd3, 8'h00);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/tone_gen.md
Name: tone_gen

Overview:
Programmable square-wave tone generator on the 8-bit I/O bus. It produces the audio-rate clock that drives the buzzer gate stage directly downstream. The CPU writes a 16-bit half-period divider, a duration count and a control byte through chip-select/write strobes. The generator then runs either continuously or for a timed burst, and reports status on busy/done.

Parameters:
DIV_W, 16, width of the half-period divider register and counter
TICK_CYCLES, 1000, clk_in cycles per duration unit (benches use 4)
DUR_W, 8, width of the duration register and counter

Ports:
clk_in  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
CS_N  input  1  chip select, active-low
IOW_N  input  1  write strobe, active-low
addr  input  2  register select: 0 div_lo, 1 div_hi, 2 dur, 3 ctrl
din  input  8  write data
tone_out  output  1  square wave to the buzzer stage clock input
busy  output  1  high while state is RUN
done  output  1  one-cycle pulse when a timed burst ends

Behaviour:
- One clock (clk_in). Reset is asynchronous and active-low (rst_n).
- Reset values: all registers and counters 0, state IDLE, tone_out 0, busy 0, done 0. Asserting rst_n low mid-burst forces these values immediately, with no clock edge needed.
- Write detection:
  - wr_act = !CS_N & !IOW_N, registered each cycle as wr_act_d.
  - Write strobe = wr_act & !wr_act_d. Exactly one commit per strobe assertion, however long the strobe is held.
  - Data and address are sampled on the strobe cycle.
- Registers:
  - div_lo and div_hi form div_reg[15:0].
  - dur_reg[7:0].
  - ctrl: bit0 EN, bit1 MODE (0 continuous, 1 timed). Other bits are ignored.
  - Writes to div/dur never change state.
- States: IDLE, RUN.
- Ctrl write with EN=1, from either state (a restart if already in RUN), committed at edge k:
  - div_cnt <= 0, tick_cnt <= 0, dur_cnt <= dur_reg, tone_out <= 0.
  - State <= RUN, except MODE=1 with dur_reg=0: state stays IDLE and done=1 for the cycle after edge k.
- Ctrl write with EN=0: state <= IDLE, tone_out <= 0, no done pulse.
- RUN divider, each edge:
  - If div_cnt == div_reg: div_cnt <= 0 and tone_out toggles; else div_cnt++.
  - First rising edge of tone_out occurs at edge k+div_reg+1.
  - Period is 2*(div_reg+1) cycles, 50% duty. div_reg=0 gives a 2-cycle period.
  - div_reg written during RUN: the comparison uses the live register, so the new value governs the next half-period. If the new value is below the current div_cnt, the count wraps at 2^DIV_W; this is accepted behaviour.
- RUN timed (MODE=1):
  - tick_cnt counts 0..TICK_CYCLES-1 and wraps.
  - On wrap, if dur_cnt == 1: state <= IDLE, tone_out <= 0, done <= 1 for one cycle. Otherwise dur_cnt--.
  - Burst length is exactly dur_reg*TICK_CYCLES cycles of busy=1.
- RUN continuous (MODE=0): tick/dur ignored; runs until an EN=0 write or reset.
- Simultaneous events:
  - A ctrl write in the same cycle as timed expiry: the write wins, and done is not pulsed.
  - A div/dur write in the same cycle as expiry: expiry proceeds and the register updates.
- busy = (state == RUN), registered. done is 0 except for the specified pulses.
- In IDLE, tone_out is held at 0, so the downstream gate sees no clock.

Test Plan:
- Reset: hold rst_n=0 with random bus activity -> tone_out=0, busy=0, done=0; release -> still 0, no write committed during reset.
- Continuous: write div_lo=2, div_hi=0, ctrl=0x01 -> busy=1 the next cycle, tone_out 3 cycles low then 3 high repeating (period 6) for 100 cycles; write ctrl=0x00 -> tone_out=0, busy=0 after the commit edge, done never pulses.
- Timed (TICK_CYCLES=4): div=0, dur=3, ctrl=0x03 -> busy high exactly 12 cycles, tone_out toggling every cycle, then done=1 for one cycle and tone_out=0.
- Long strobe: hold CS_N=IOW_N=0 for 5 cycles with addr=3, din=0x03, dur=2 -> a single start, busy exactly 8 cycles (no restarts); mid-run write div_hi=0x01 -> subsequent half-periods 0x101+... i.e. 258 cycles.
- Timed with dur=0: ctrl=0x03 -> done pulse one cycle after commit, busy stays 0, tone_out stays 0.
- Async reset mid-burst: assert rst_n=0 between clock edges during RUN -> tone_out, busy, done drop to 0 immediately; after release, div/dur read as reset (a start with MODE=1 gives the dur=0 behaviour).
